exec_wb_stage: RTL and testbench

Execute/writeback stage sitting between the decode front end and the 32x32 register file. It accepts one decoded ALU operation per handshake and drives the register file's two combinational read ports. It computes the result and, two cycles later, drives the register file's write port. Two forwarding paths resolve read-after-write hazards, and an iterative multiplier provides MUL, stalling the input while it runs.

---
 rtl/exec_pkg.sv | 43 ++++
 rtl/exec_wb_stage_if.sv | 30 +++
 rtl/exec_wb_stage_seq_multiplier.sv | 54 +++++
 rtl/exec_wb_stage.sv | 131 +++++++++++++
 tb/tb_exec_wb_stage.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared opcodes, E-stage state encoding and pipeline payload types for the
// execute/writeback stage.
package exec_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REGS_LOG2 = 5;
   localparam int unsigned OP_W      = 4;
   localparam int unsigned SHAMT_W   = $clog2(XLEN);

   localparam logic [OP_W-1:0] OP_ADD = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB = 4'd1;
   localparam logic [OP_W-1:0] OP_AND = 4'd2;
   localparam logic [OP_W-1:0] OP_OR  = 4'd3;
   localparam logic [OP_W-1:0] OP_XOR = 4'd4;
   localparam logic [OP_W-1:0] OP_SLT = 4'd5;
   localparam logic [OP_W-1:0] OP_SLL = 4'd6;
   localparam logic [OP_W-1:0] OP_SRL = 4'd7;
   localparam logic [OP_W-1:0] OP_SRA = 4'd8;
   localparam logic [OP_W-1:0] OP_MUL = 4'd9;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ALU     = 2'd1;
   localparam logic [1:0] ST_MUL_RUN = 2'd2;

   typedef struct packed {
      logic [OP_W-1:0]      op;
      logic [REGS_LOG2-1:0] rd;
      logic [XLEN-1:0]      a;
      logic [XLEN-1:0]      b;
   } eStage_t;

   typedef struct packed {
      logic                 wrEnable;
      logic [REGS_LOG2-1:0] wrReg;
      logic [XLEN-1:0]      wrData;
   } wStage_t;

   // Opcodes 10..15 are NOPs and never write the register file.
   function automatic logic opWrites(input logic [OP_W-1:0] op);
      return op <= OP_MUL;
   endfunction

endpackage

// File: rtl/exec_wb_stage_if.sv
// Decode handshake plus register-file read/write ports of the execute/writeback stage.
interface exec_wb_stage_if;
   import exec_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [OP_W-1:0]      in_op;
   logic [REGS_LOG2-1:0] in_rs1;
   logic [REGS_LOG2-1:0] in_rs2;
   logic [REGS_LOG2-1:0] in_rd;
   logic [REGS_LOG2-1:0] rdReg1;
   logic [REGS_LOG2-1:0] rdReg2;
   logic [XLEN-1:0]      rdData1;
   logic [XLEN-1:0]      rdData2;
   logic                 wrEnable;
   logic [REGS_LOG2-1:0] wrReg;
   logic [XLEN-1:0]      wrData;
   logic                 busy;

   modport master (
      output in_valid, in_op, in_rs1, in_rs2, in_rd, rdData1, rdData2,
      input  in_ready, rdReg1, rdReg2, wrEnable, wrReg, wrData, busy
   );

   modport slave (
      input  in_valid, in_op, in_rs1, in_rs2, in_rd, rdData1, rdData2,
      output in_ready, rdReg1, rdReg2, wrEnable, wrReg, wrData, busy
   );

endinterface

// File: rtl/exec_wb_stage_seq_multiplier.sv
// 32-iteration shift-add multiplier; done and product_lo are valid together
// during the final iteration so the caller can capture on that edge.
module seq_multiplier
   import exec_pkg::*;
#(
   parameter int unsigned W = XLEN
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] product_lo
);

   localparam int unsigned      CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);

   logic             running;
   logic [CNT_W-1:0] count;
   logic [W-1:0]     acc;
   logic [W-1:0]     aShift;
   logic [W-1:0]     bShift;

   // Accumulator including the current iteration's partial product.
   assign product_lo = acc + (bShift[0] ? aShift : '0);
   assign done       = running && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running <= 1'b0;
         count   <= '0;
         acc     <= '0;
         aShift  <= '0;
         bShift  <= '0;
      end else if (start) begin
         running <= 1'b1;
         count   <= '0;
         acc     <= '0;
         aShift  <= a;
         bShift  <= b;
      end else if (running) begin
         acc    <= product_lo;
         aShift <= aShift << 1;
         bShift <= bShift >> 1;
         count  <= count + CNT_W'(1);
         if (count == LAST) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/writeback stage: captures forwarded operands, runs the ALU or the
// iterative multiplier in E, and drives the register-file write port from W.
module exec_wb_stage
   import exec_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   exec_wb_stage_if.slave  bus
);

   logic [1:0]         state;
   logic [1:0]         stateNext;
   eStage_t            eReg;
   wStage_t            wReg;
   wStage_t            wNext;
   logic               busyReg;
   logic               accept;
   logic               eFwd;
   logic               mulStart;
   logic               mulDone;
   logic [XLEN-1:0]    mulProduct;
   logic [XLEN-1:0]    aluResult;
   logic [XLEN-1:0]    opA;
   logic [XLEN-1:0]    opB;
   logic [SHAMT_W-1:0] shamt;

   assign bus.in_ready = (state != ST_MUL_RUN);
   assign bus.rdReg1   = bus.in_rs1;
   assign bus.rdReg2   = bus.in_rs2;
   assign bus.wrEnable = wReg.wrEnable;
   assign bus.wrReg    = wReg.wrReg;
   assign bus.wrData   = wReg.wrData;
   assign bus.busy     = busyReg;

   assign accept   = bus.in_valid && bus.in_ready;
   assign mulStart = accept && (bus.in_op == OP_MUL);
   assign eFwd     = (state == ST_ALU) && opWrites(eReg.op);
   assign shamt    = eReg.b[SHAMT_W-1:0];

   // Single-cycle ALU on the operands held in E.
   always_comb begin
      aluResult = '0;
      case (eReg.op)
         OP_ADD:  aluResult = eReg.a + eReg.b;
         OP_SUB:  aluResult = eReg.a - eReg.b;
         OP_AND:  aluResult = eReg.a & eReg.b;
         OP_OR:   aluResult = eReg.a | eReg.b;
         OP_XOR:  aluResult = eReg.a ^ eReg.b;
         OP_SLT:  aluResult = XLEN'($signed(eReg.a) < $signed(eReg.b));
         OP_SLL:  aluResult = eReg.a << shamt;
         OP_SRL:  aluResult = eReg.a >> shamt;
         OP_SRA:  aluResult = $unsigned($signed(eReg.a) >>> shamt);
         default: aluResult = '0;
      endcase
   end

   // Operand forwarding: the younger E result wins over W, W over the register file.
   always_comb begin
      opA = bus.rdData1;
      if (eFwd && (eReg.rd == bus.in_rs1)) begin
         opA = aluResult;
      end else if (wReg.wrEnable && (wReg.wrReg == bus.in_rs1)) begin
         opA = wReg.wrData;
      end
      opB = bus.rdData2;
      if (eFwd && (eReg.rd == bus.in_rs2)) begin
         opB = aluResult;
      end else if (wReg.wrEnable && (wReg.wrReg == bus.in_rs2)) begin
         opB = wReg.wrData;
      end
   end

   seq_multiplier #(.W(XLEN)) u_mul (
      .clk        (clk),
      .rst        (rst),
      .start      (mulStart),
      .a          (opA),
      .b          (opB),
      .done       (mulDone),
      .product_lo (mulProduct)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next E state and the value W loads on this edge.
   always_comb begin
      stateNext      = state;
      wNext          = wReg;
      wNext.wrEnable = 1'b0;
      case (state)
         ST_IDLE, ST_ALU: begin
            if (accept) begin
               stateNext = (bus.in_op == OP_MUL) ? ST_MUL_RUN : ST_ALU;
            end else begin
               stateNext = ST_IDLE;
            end
            wNext = '{wrEnable: eFwd, wrReg: eReg.rd, wrData: aluResult};
         end
         ST_MUL_RUN: begin
            if (mulDone) begin
               stateNext = ST_IDLE;
               wNext     = '{wrEnable: 1'b1, wrReg: eReg.rd, wrData: mulProduct};
            end
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eReg    <= '0;
         wReg    <= '0;
         busyReg <= 1'b0;
      end else begin
         if (accept) begin
            eReg <= '{op: bus.in_op, rd: bus.in_rd, a: opA, b: opB};
         end
         wReg    <= wNext;
         busyReg <= (stateNext != ST_IDLE) || wNext.wrEnable;
      end
   end

endmodule

// File: tb/tb_exec_wb_stage.sv
// Randomized and directed bench for exec_wb_stage against an in-order
// architectural register model with expected write times.
module tb_exec_wb_stage;
   import exec_pkg::*;

   typedef struct {
      int          due;
      logic [4:0]  rd;
      logic [31:0] val;
   } expWr_t;

   logic        clk;
   logic        rst;
   logic [31:0] rf [32];
   logic [31:0] specRegs [32];
   logic [31:0] commitRegs [32];
   bit          busyMap [8192];
   expWr_t      expQ [$];
   int          cyc;
   int          nrFrom;
   int          nrTo;
   int          nChecks;
   int          nPass;

   exec_wb_stage_if bus ();

   exec_wb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.rdData1 = rf[bus.rdReg1];
   assign bus.rdData2 = rf[bus.rdReg2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic [63:0]        prod;
      sa   = a;
      prod = {32'd0, a} * {32'd0, b};
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return (sa < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    return a << b[4:0];
         4'd7:    return a >> b[4:0];
         4'd8:    return sa >>> b[4:0];
         4'd9:    return prod[31:0];
         default: return 32'd0;
      endcase
   endfunction

   // Program-order semantics: the op sees every older op's result.
   task automatic modelAccept(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      logic [31:0] res;
      int          endC;
      res = refAlu(op, specRegs[rs1], specRegs[rs2]);
      if (op == OP_MUL) begin
         expQ.push_back('{due: cyc + 33, rd: rd, val: res});
         endC   = cyc + 33;
         nrFrom = cyc + 1;
         nrTo   = cyc + 32;
      end else if (op <= OP_SRA) begin
         expQ.push_back('{due: cyc + 2, rd: rd, val: res});
         endC = cyc + 2;
      end else begin
         endC = cyc + 1;
      end
      if (op <= OP_MUL) specRegs[rd] = res;
      for (int i = cyc + 1; i <= endC; i++) busyMap[i] = 1'b1;
   endtask

   task automatic doCycle(input logic v, input logic [3:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, output logic acc);
      logic        expWr;
      logic        ready;
      logic        pwEn;
      logic [4:0]  pwReg;
      logic [31:0] pwData;
      @(negedge clk);
      expWr = (expQ.size() > 0) && (expQ[0].due == cyc);
      checkVal("wrEnable", 32'(bus.wrEnable), 32'(expWr));
      if (expWr) begin
         checkVal("wrReg", 32'(bus.wrReg), 32'(expQ[0].rd));
         checkVal("wrData", bus.wrData, expQ[0].val);
         commitRegs[expQ[0].rd] = expQ[0].val;
         void'(expQ.pop_front());
      end
      ready = !((cyc >= nrFrom) && (cyc <= nrTo));
      checkVal("in_ready", 32'(bus.in_ready), 32'(ready));
      checkVal("busy", 32'(bus.busy), 32'(busyMap[cyc]));
      pwEn   = bus.wrEnable;
      pwReg  = bus.wrReg;
      pwData = bus.wrData;
      bus.in_valid = v;
      bus.in_op    = op;
      bus.in_rd    = rd;
      bus.in_rs1   = rs1;
      bus.in_rs2   = rs2;
      acc = v && ready;
      if (acc) modelAccept(op, rd, rs1, rs2);
      #1;
      checkVal("rdReg1", 32'(bus.rdReg1), 32'(rs1));
      @(posedge clk);
      cyc++;
      #1;
      if (pwEn) rf[pwReg] = pwData;
   endtask

   task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 100) begin
         doCycle(1'b1, op, rd, rs1, rs2, acc);
         tries++;
      end
      if (!acc) checkVal("issue_timeout", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) doCycle(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, acc);
   endtask

   task automatic setReg(input int idx, input logic [31:0] val);
      rf[idx]         = val;
      specRegs[idx]   = val;
      commitRegs[idx] = val;
   endtask

   // Asynchronous reset asserted mid-cycle, away from the clock edge.
   task automatic resetMid();
      #1 rst = 1'b1;
      #1;
      checkVal("rst_wrEnable", 32'(bus.wrEnable), 32'd0);
      checkVal("rst_wrReg", 32'(bus.wrReg), 32'd0);
      checkVal("rst_wrData", bus.wrData, 32'd0);
      checkVal("rst_busy", 32'(bus.busy), 32'd0);
      checkVal("rst_in_ready", 32'(bus.in_ready), 32'd1);
      expQ.delete();
      specRegs = commitRegs;
      nrFrom   = 1;
      nrTo     = 0;
      for (int i = cyc; i < 8192; i++) busyMap[i] = 1'b0;
      @(posedge clk);
      cyc++;
      #1 rst = 1'b0;
   endtask

   initial begin
      logic       acc;
      logic       v;
      logic [3:0] op;
      int         r;

      nChecks = 0;
      nPass   = 0;
      cyc     = 0;
      nrFrom  = 1;
      nrTo    = 0;
      rst     = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_op    = 4'd0;
      bus.in_rd    = 5'd0;
      bus.in_rs1   = 5'd0;
      bus.in_rs2   = 5'd0;
      for (int i = 0; i < 32; i++) setReg(i, 32'd0);
      #1;
      checkVal("reset_wrEnable", 32'(bus.wrEnable), 32'd0);
      checkVal("reset_wrData", bus.wrData, 32'd0);
      checkVal("reset_in_ready", 32'(bus.in_ready), 32'd1);
      checkVal("reset_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      cyc++;
      #1 rst = 1'b0;

      // ADD r3 <- r1 + r2
      setReg(1, 32'd5);
      setReg(2, 32'd7);
      issue(OP_ADD, 5'd3, 5'd1, 5'd2);
      idle(3);
      checkVal("plan_add_r3", rf[3], 32'd12);

      // Dependent chain exercising E and W forwarding
      setReg(1, 32'd1);
      issue(OP_ADD, 5'd2, 5'd1, 5'd1);
      issue(OP_ADD, 5'd3, 5'd2, 5'd2);
      issue(OP_ADD, 5'd4, 5'd3, 5'd2);
      idle(3);
      checkVal("chain_r2", rf[2], 32'd2);
      checkVal("chain_r3", rf[3], 32'd4);
      checkVal("chain_r4", rf[4], 32'd6);

      // Boundary ALU cases
      setReg(5, 32'd0);
      setReg(6, 32'd1);
      setReg(7, 32'hFFFF_FFFF);
      setReg(8, 32'h8000_0000);
      setReg(9, 32'd31);
      setReg(10, 32'd33);
      issue(OP_SUB, 5'd11, 5'd5, 5'd6);
      issue(OP_SLT, 5'd12, 5'd7, 5'd6);
      issue(OP_SRA, 5'd13, 5'd8, 5'd9);
      issue(OP_SLL, 5'd14, 5'd6, 5'd10);
      idle(3);
      checkVal("sub_wrap", rf[11], 32'hFFFF_FFFF);
      checkVal("slt_signed", rf[12], 32'd1);
      checkVal("sra_sign", rf[13], 32'hFFFF_FFFF);
      checkVal("sll_mod32", rf[14], 32'd2);

      // MUL followed by a dependent ADD
      setReg(1, 32'h0001_0001);
      setReg(2, 32'h0000_FFFF);
      issue(OP_MUL, 5'd3, 5'd1, 5'd2);
      issue(OP_ADD, 5'd4, 5'd3, 5'd3);
      idle(4);
      checkVal("mul_r3", rf[3], 32'hFFFF_FFFF);
      checkVal("mul_dep_r4", rf[4], 32'hFFFF_FFFE);

      // Reset at MUL iteration 10
      setReg(20, 32'h0000_1234);
      setReg(1, 32'd3);
      setReg(2, 32'd4);
      issue(OP_MUL, 5'd20, 5'd1, 5'd2);
      idle(10);
      resetMid();
      issue(OP_ADD, 5'd21, 5'd1, 5'd2);
      idle(40);
      checkVal("abandoned_mul_r20", rf[20], 32'h0000_1234);
      checkVal("post_reset_add_r21", rf[21], 32'd7);

      // Randomized traffic on a small register window to provoke hazards
      for (int i = 0; i < 8; i++) setReg(i, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 9) < 8);
         r = $urandom_range(0, 99);
         if (r < 6) op = OP_MUL;
         else if (r < 12) op = 4'($urandom_range(10, 15));
         else op = 4'($urandom_range(0, 8));
         doCycle(v, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
      end
      idle(40);
      for (int i = 0; i < 32; i++) checkVal($sformatf("final_rf%0d", i), rf[i], commitRegs[i]);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
